// File: rtl/write_back_unit_if.sv
// Bus bundle between the execute stage, data memory and the register file
// for the write-back unit. The slave modport is the write-back unit's view.
interface write_back_unit_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int GPR_WIDTH   = 3,
  parameter int COUNT_WIDTH = 16
);
  logic                   halt;
  logic                   exec_valid;
  logic                   exec_is_load;
  logic [GPR_WIDTH-1:0]   exec_dest;
  logic [DATA_WIDTH-1:0]  exec_result;
  logic                   mem_rvalid;
  logic [DATA_WIDTH-1:0]  mem_rdata;
  logic                   write_enable;
  logic [GPR_WIDTH-1:0]   write_address;
  logic [DATA_WIDTH-1:0]  write_data;
  logic                   stall;
  logic [GPR_WIDTH-1:0]   busy_address;
  logic                   load_error;
  logic [COUNT_WIDTH-1:0] writes_retired;

  modport slave (
    input  halt, exec_valid, exec_is_load, exec_dest, exec_result,
    input  mem_rvalid, mem_rdata,
    output write_enable, write_address, write_data,
    output stall, busy_address, load_error, writes_retired
  );

  modport master (
    output halt, exec_valid, exec_is_load, exec_dest, exec_result,
    output mem_rvalid, mem_rdata,
    input  write_enable, write_address, write_data,
    input  stall, busy_address, load_error, writes_retired
  );
endinterface

// File: rtl/write_back_unit.sv
// Write-back stage: commits ALU results immediately, parks on loads until
// the data-memory response arrives (stalling upstream), flags lost or stray
// memory responses and counts committed register writes.
module write_back_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int GPR_WIDTH    = 3,
  parameter int LOAD_TIMEOUT = 16,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic               clock,
  input  logic               reset,
  write_back_unit_if.slave   bus
);

  localparam int TW = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST_COUNT = TW'(LOAD_TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t                 state;
  state_t                 next_state;
  logic [TW-1:0]          wait_count;
  logic                   do_write;
  logic [GPR_WIDTH-1:0]   next_address;
  logic [DATA_WIDTH-1:0]  next_data;
  logic                   set_error;
  logic                   accept_load;
  logic                   count_up;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state: a response always wins over the timeout; halt freezes both
  // acceptance of new work and the timeout itself
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!bus.halt && bus.exec_valid && bus.exec_is_load) next_state = WAIT_MEM;
      end
      WAIT_MEM: begin
        if (bus.mem_rvalid)                             next_state = IDLE;
        else if (!bus.halt && wait_count == LAST_COUNT) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode: what to commit this edge, and whether to raise the error
  always_comb begin
    do_write     = 1'b0;
    next_address = '0;
    next_data    = '0;
    set_error    = 1'b0;
    accept_load  = 1'b0;
    count_up     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_rvalid) set_error = 1'b1;
        if (!bus.halt && bus.exec_valid) begin
          if (bus.exec_is_load) begin
            accept_load = 1'b1;
          end else begin
            do_write     = 1'b1;
            next_address = bus.exec_dest;
            next_data    = bus.exec_result;
          end
        end
      end
      WAIT_MEM: begin
        if (bus.mem_rvalid) begin
          do_write     = 1'b1;
          next_address = bus.busy_address;
          next_data    = bus.mem_rdata;
        end else if (!bus.halt) begin
          if (wait_count == LAST_COUNT) set_error = 1'b1;
          else                          count_up  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered datapath: write port, pending-load tracking, error and counter
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.write_enable   <= 1'b0;
      bus.write_address  <= '0;
      bus.write_data     <= '0;
      bus.busy_address   <= '0;
      bus.load_error     <= 1'b0;
      bus.writes_retired <= '0;
      wait_count         <= '0;
    end else begin
      bus.write_enable <= do_write;
      if (do_write) begin
        bus.write_address  <= next_address;
        bus.write_data     <= next_data;
        bus.writes_retired <= bus.writes_retired + COUNT_WIDTH'(1);
      end
      if (accept_load) begin
        bus.busy_address <= bus.exec_dest;
        wait_count       <= '0;
      end else if (count_up) begin
        wait_count <= wait_count + TW'(1);
      end
      if (set_error) bus.load_error <= 1'b1;
    end
  end

  // Stall is purely the waiting state so upstream sees it without delay
  always_comb bus.stall = (state == WAIT_MEM);

endmodule

// File: tb/tb_write_back_unit.sv
// Directed self-checking bench for write_back_unit. A second instance with a
// 4-bit retired counter shares the stimulus to exercise counter wrap.
module tb_write_back_unit;
  localparam int DW = 32;
  localparam int GW = 3;
  localparam int LT = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  write_back_unit_if #(.DATA_WIDTH(DW), .GPR_WIDTH(GW), .COUNT_WIDTH(16)) bus ();
  write_back_unit_if #(.DATA_WIDTH(DW), .GPR_WIDTH(GW), .COUNT_WIDTH(4))  bus4 ();

  write_back_unit #(.DATA_WIDTH(DW), .GPR_WIDTH(GW), .LOAD_TIMEOUT(LT), .COUNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave)
  );
  write_back_unit #(.DATA_WIDTH(DW), .GPR_WIDTH(GW), .LOAD_TIMEOUT(LT), .COUNT_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .bus(bus4.slave)
  );

  assign bus4.halt         = bus.halt;
  assign bus4.exec_valid   = bus.exec_valid;
  assign bus4.exec_is_load = bus.exec_is_load;
  assign bus4.exec_dest    = bus.exec_dest;
  assign bus4.exec_result  = bus.exec_result;
  assign bus4.mem_rvalid   = bus.mem_rvalid;
  assign bus4.mem_rdata    = bus.mem_rdata;

  always #5 clock = ~clock;

  // Count one comparison and report it if it disagrees
  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic is_load, input logic [GW-1:0] dest,
                                input logic [DW-1:0] result, input logic rvalid, input logic [DW-1:0] rdata);
    bus.exec_valid   = valid;
    bus.exec_is_load = is_load;
    bus.exec_dest    = dest;
    bus.exec_result  = result;
    bus.mem_rvalid   = rvalid;
    bus.mem_rdata    = rdata;
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic check_write(input string tag, input logic [GW-1:0] addr, input logic [DW-1:0] data);
    check_output({tag, ".we"},   bus.write_enable, 1);
    check_output({tag, ".addr"}, bus.write_address, addr);
    check_output({tag, ".data"}, bus.write_data, data);
  endtask

  initial begin
    bus.halt = 1'b0;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    check_output("rst.we",      bus.write_enable, 0);
    check_output("rst.addr",    bus.write_address, 0);
    check_output("rst.data",    bus.write_data, 0);
    check_output("rst.stall",   bus.stall, 0);
    check_output("rst.busy",    bus.busy_address, 0);
    check_output("rst.err",     bus.load_error, 0);
    check_output("rst.retired", bus.writes_retired, 0);
    reset = 1'b0;

    // Single ALU commit
    apply_stimulus(1'b1, 1'b0, 3'd3, 32'hDEADBEEF, 1'b0, '0);
    tick();
    check_write("alu1", 3'd3, 32'hDEADBEEF);
    idle_inputs();
    tick();
    check_output("alu1.we_off", bus.write_enable, 0);
    check_output("alu1.retired", bus.writes_retired, 1);

    // Back-to-back ALU commits
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(1'b1, 1'b0, GW'(i), 32'h100 + i, 1'b0, '0);
      tick();
      check_write($sformatf("b2b%0d", i), GW'(i), 32'h100 + i);
      check_output($sformatf("b2b%0d.stall", i), bus.stall, 0);
    end
    idle_inputs();
    tick();
    check_output("b2b.we_off", bus.write_enable, 0);
    check_output("b2b.retired", bus.writes_retired, 5);

    // Load answered after three waiting cycles; ALU traffic during the wait is ignored
    apply_stimulus(1'b1, 1'b1, 3'd5, '0, 1'b0, '0);
    tick();
    check_output("ld.stall", bus.stall, 1);
    check_output("ld.busy", bus.busy_address, 5);
    check_output("ld.we", bus.write_enable, 0);
    apply_stimulus(1'b1, 1'b0, 3'd7, 32'hBAD0BAD0, 1'b0, '0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_output($sformatf("ld.wait%0d.stall", i), bus.stall, 1);
      check_output($sformatf("ld.wait%0d.we", i), bus.write_enable, 0);
    end
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 32'h12345678);
    tick();
    check_write("ld.commit", 3'd5, 32'h12345678);
    check_output("ld.commit.stall", bus.stall, 0);
    idle_inputs();
    tick();
    check_output("ld.retired", bus.writes_retired, 6);

    // Load that never gets a response times out
    apply_stimulus(1'b1, 1'b1, 3'd6, '0, 1'b0, '0);
    tick();
    idle_inputs();
    for (int i = 0; i < LT - 1; i++) tick();
    check_output("to.pre.stall", bus.stall, 1);
    check_output("to.pre.err", bus.load_error, 0);
    tick();
    check_output("to.stall", bus.stall, 0);
    check_output("to.err", bus.load_error, 1);
    check_output("to.we", bus.write_enable, 0);
    apply_stimulus(1'b1, 1'b0, 3'd2, 32'h0000A5A5, 1'b0, '0);
    tick();
    check_write("to.alu", 3'd2, 32'h0000A5A5);
    idle_inputs();
    tick();
    check_output("to.retired", bus.writes_retired, 7);
    check_output("to.err_sticky", bus.load_error, 1);

    // Response on the exact timeout edge commits normally
    reset = 1'b1;
    tick();
    reset = 1'b0;
    apply_stimulus(1'b1, 1'b1, 3'd4, '0, 1'b0, '0);
    tick();
    idle_inputs();
    for (int i = 0; i < LT - 1; i++) tick();
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 32'hCAFEF00D);
    tick();
    check_write("edge", 3'd4, 32'hCAFEF00D);
    check_output("edge.err", bus.load_error, 0);
    check_output("edge.stall", bus.stall, 0);
    idle_inputs();
    tick();

    // Halt freezes the timeout while a load is pending
    apply_stimulus(1'b1, 1'b1, 3'd1, '0, 1'b0, '0);
    tick();
    idle_inputs();
    bus.halt = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check_output("halt.stall", bus.stall, 1);
    check_output("halt.err", bus.load_error, 0);
    bus.halt = 1'b0;
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 32'h00000055);
    tick();
    check_write("halt.commit", 3'd1, 32'h00000055);
    idle_inputs();
    tick();
    check_output("halt.retired", bus.writes_retired, 2);

    // Halt in idle blocks ALU acceptance
    bus.halt = 1'b1;
    apply_stimulus(1'b1, 1'b0, 3'd6, 32'h11111111, 1'b0, '0);
    tick();
    check_output("halt_idle.we", bus.write_enable, 0);
    bus.halt = 1'b0;
    idle_inputs();
    tick();

    // Stray response with a simultaneous ALU write to register 0
    apply_stimulus(1'b1, 1'b0, 3'd0, 32'h00000077, 1'b1, 32'hFFFFFFFF);
    tick();
    check_write("stray", 3'd0, 32'h00000077);
    check_output("stray.err", bus.load_error, 1);
    idle_inputs();
    tick();
    check_output("stray.retired", bus.writes_retired, 3);

    // Reset in the middle of a pending load discards it
    apply_stimulus(1'b1, 1'b1, 3'd3, '0, 1'b0, '0);
    tick();
    check_output("rstmid.stall_before", bus.stall, 1);
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 32'h99999999);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    check_output("rstmid.we", bus.write_enable, 0);
    check_output("rstmid.stall", bus.stall, 0);
    check_output("rstmid.busy", bus.busy_address, 0);
    check_output("rstmid.err", bus.load_error, 0);
    check_output("rstmid.retired", bus.writes_retired, 0);
    check_output("rstmid.data", bus.write_data, 0);

    // Seventeen writes: wide counter reads 17, 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(1'b1, 1'b0, GW'(i % 8), 32'h2000 + i, 1'b0, '0);
      tick();
    end
    idle_inputs();
    tick();
    check_output("wrap.wide", bus.writes_retired, 17);
    check_output("wrap.narrow", bus4.writes_retired, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time guard so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end
endmodule
